// File: rtl/operand_drain.sv
// Drains up to three accumulator operand slots downstream over a valid/ready
// handshake, lowest index first, then pulses clear to release the slots.
module operand_drain #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] r0,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic              r0_valid,
  input  logic              r1_valid,
  input  logic              r2_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              clear,
  output logic              busy,
  output logic [1:0]        count,
  output logic              err_empty
);

  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_t;

  state_t                   state;
  logic [2:0][DATA_W-1:0]   snap_data;
  logic [2:0]               pend;       // captured valid slots not yet handed off
  logic [2:0][DATA_W-1:0]   in_data;
  logic [2:0]               in_vld;
  logic [2:0]               pend_rem;

  assign in_data  = {r2, r1, r0};
  assign in_vld   = {r2_valid, r1_valid, r0_valid};
  assign pend_rem = pend & ~(3'b001 << out_idx);

  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      lowest = 2'd0;
    else if (m[1]) lowest = 2'd1;
    else           lowest = 2'd2;
  endfunction

  function automatic logic single(input logic [2:0] m);
    single = (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      snap_data <= '0;
      pend      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
      clear     <= 1'b0;
      busy      <= 1'b0;
      count     <= 2'd0;
      err_empty <= 1'b0;
    end else begin
      err_empty <= 1'b0;
      clear     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (|in_vld) begin
              // First operand is offered straight from the inputs so out_valid
              // rises in the cycle right after start.
              snap_data <= in_data;
              pend      <= in_vld;
              count     <= 2'd0;
              state     <= SEND;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= in_data[lowest(in_vld)];
              out_idx   <= lowest(in_vld);
              out_last  <= single(in_vld);
            end else begin
              err_empty <= 1'b1;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            pend <= pend_rem;
            if (count != 2'd3) count <= count + 2'd1;
            if (pend_rem == 3'b000) begin
              state     <= CLEAR;
              clear     <= 1'b1;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_idx   <= 2'd0;
              out_last  <= 1'b0;
            end else begin
              out_data <= snap_data[lowest(pend_rem)];
              out_idx  <= lowest(pend_rem);
              out_last <= single(pend_rem);
            end
          end
        end
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
